// File: rtl/column_feed.sv
// Raster pixels in, HEIGHT_NB-tall column vectors out via LINE_LEN-deep line buffers.
// Define COLUMN_FEED_ZERO_PAD_EN to emit from row 0 with missing rows zero-padded.
module column_feed #(
    parameter int HEIGHT_NB = 3,
    parameter int IMG_WIDTH = 8,
    parameter int LINE_LEN  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IMG_WIDTH-1:0]           up_pix,
    input  logic                           up_val,
    input  logic                           up_sof,
    output logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img,
    output logic                           dn_val,
    output logic                           dn_eol
);

    localparam int CW = $clog2(LINE_LEN);
    localparam int RW = $clog2(HEIGHT_NB);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_NB - 1);

    logic [CW-1:0]                  col;
    logic [CW-1:0]                  cur_col;
    logic [RW-1:0]                  row;
    logic [RW-1:0]                  cur_row;
    logic [IMG_WIDTH-1:0]           lb [HEIGHT_NB-1][LINE_LEN];
    logic [HEIGHT_NB*IMG_WIDTH-1:0] col_vec;
    logic                           emit;
    logic                           at_eol;

    // A start-of-frame pixel is forced to the frame origin.
    assign cur_col = up_sof ? '0 : col;
    assign cur_row = up_sof ? '0 : row;
    assign at_eol  = (cur_col == COL_LAST);

`ifdef COLUMN_FEED_ZERO_PAD_EN
    assign emit = 1'b1;
`else
    assign emit = (cur_row == ROW_LAST);
`endif

    always_comb begin
        col_vec = '0;
        col_vec[IMG_WIDTH-1:0] = up_pix;
        for (int k = 1; k < HEIGHT_NB; k++) begin
`ifdef COLUMN_FEED_ZERO_PAD_EN
            // Rows above the frame top have no data yet; present them as zero.
            if (k <= int'(cur_row))
                col_vec[k*IMG_WIDTH +: IMG_WIDTH] = lb[k-1][cur_col];
`else
            col_vec[k*IMG_WIDTH +: IMG_WIDTH] = lb[k-1][cur_col];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            dn_val <= 1'b0;
            dn_eol <= 1'b0;
            dn_img <= '0;
        end else begin
            dn_val <= up_val && emit;
            dn_eol <= up_val && emit && at_eol;
            if (up_val) begin
                col <= at_eol ? '0 : cur_col + 1'b1;
                if (at_eol && cur_row != ROW_LAST)
                    row <= cur_row + 1'b1;
                else
                    row <= cur_row;
                if (emit)
                    dn_img <= col_vec;
            end
        end
    end

    // Line buffers carry no reset; stale data is masked by the row gating.
    always_ff @(posedge clk) begin
        if (up_val && !rst) begin
            lb[0][cur_col] <= up_pix;
            for (int k = 1; k < HEIGHT_NB - 1; k++)
                lb[k][cur_col] <= lb[k-1][cur_col];
        end
    end

endmodule

// File: doc/column_feed.md
COLUMN_FEED -- requirements
Module: column_feed

Interface
REQ-001 Parameter HEIGHT_NB, default 3, rows per output column vector; SHALL be >= 2.
REQ-002 Parameter IMG_WIDTH, default 8, pixel width in bits.
REQ-003 Parameter LINE_LEN, default 64, pixels per image line; SHALL be >= 2.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 up_pix  input  IMG_WIDTH  raster-order pixel.
REQ-007 up_val  input  1  up_pix valid; no backpressure, pixel consumed every cycle up_val=1.
REQ-008 up_sof  input  1  start of frame, qualified by up_val.
REQ-009 dn_img  output  HEIGHT_NB*IMG_WIDTH  column vector; slice h at bits [h*IMG_WIDTH +: IMG_WIDTH], h=0 newest row, h=HEIGHT_NB-1 oldest row, directly drives a downstream filter's up_img.
REQ-010 dn_val  output  1  dn_img valid.
REQ-011 dn_eol  output  1  dn_img is last column of a line, qualified by dn_val.

Function
REQ-012 Column counter col SHALL advance by 1 per accepted pixel (up_val=1) and wrap from LINE_LEN-1 to 0.
REQ-013 Row counter row SHALL increment on each col wrap and saturate at HEIGHT_NB-1.
REQ-014 Accepted pixel with up_sof=1 SHALL be treated as col=0,row=0; counters continue from col=1,row=0.
REQ-015 HEIGHT_NB-1 line buffers of LINE_LEN entries each (buf[0]..buf[HEIGHT_NB-2]); buf[k][c] SHALL hold the pixel from column c, k+1 lines earlier.
REQ-016 On accepted pixel at column c: output slice 0 = up_pix, slice k (k>=1) = buf[k-1][c] read before write; then buf[0][c] <= up_pix, buf[k][c] <= old buf[k-1][c].
REQ-017 Line buffers SHALL change only on accepted pixels; idle cycles (up_val=0) SHALL not shift or alter data.
REQ-018 dn_img, dn_val, dn_eol SHALL be registered with latency exactly 1 cycle from the accepting up_val cycle.
REQ-019 dn_eol SHALL be 1 iff the accepted pixel had col=LINE_LEN-1 and dn_val=1.
REQ-020 dn_val SHALL be 0 in any cycle after a cycle with up_val=0.
REQ-021 dn_img SHALL hold its last value while dn_val=0.
REQ-022 up_sof mid-line SHALL abort current line; buffer contents are not cleared, only masked/suppressed per REQ-028/029.

Reset
REQ-023 rst=1 SHALL set col=0, row=0, dn_val=0, dn_eol=0, dn_img=0 at the next edge.
REQ-024 Line buffer contents SHALL not be reset; stale data SHALL never appear on a valid output (REQ-028/029).
REQ-025 rst mid-frame SHALL discard the frame; next accepted pixel is col=0,row=0 regardless of up_sof.
REQ-026 rst SHALL dominate up_val in the same cycle; that pixel is dropped.

Configuration
REQ-027 Macro COLUMN_FEED_ZERO_PAD_EN selects top-border handling.
REQ-028 With COLUMN_FEED_ZERO_PAD_EN defined: dn_val SHALL assert for every accepted pixel from row 0; slice k SHALL be forced to 0 when k > row.
REQ-029 Without it: dn_val SHALL assert only for pixels accepted with row = HEIGHT_NB-1; earlier rows only fill buffers.

Verification
REQ-030 HEIGHT_NB=3, LINE_LEN=4, no macro: sof + pixels 1..12 continuous -> dn_val only for pixels 9..12, first dn_img slices {h0,h1,h2}={9,5,1}, dn_eol with pixel 12.
REQ-031 Same, macro defined: dn_val for all 12; pixel 1 -> {1,0,0}, pixel 5 -> {5,1,0}, pixel 9 -> {9,5,1}; dn_eol at pixels 4,8,12.
REQ-032 Pixels 1..12 with up_val toggling 1/0 every cycle -> same dn_img sequence as REQ-030, dn_val pulses one cycle after each accepted pixel, never otherwise.
REQ-033 Pixels 1..6 then sof with pixels 101..112 -> no macro: first dn_val at pixel 109 with {109,105,101}; no output containing pixels 1..6.
REQ-034 rst asserted after pixel 7, then pixels 201..212 without sof -> dn_val/dn_eol/dn_img 0 cycle after rst; outputs match REQ-030 pattern offset by 200.
REQ-035 Continuous frame of 3 lines then next sof immediately -> row restarts 0, no macro: no dn_val for new frame's first 8 pixels.
